scan_decoder: RTL

- Parametrised N-to-2^N one-hot decoder with registered outputs.
- Two operating modes:
  - Direct: decodes a select value on a valid strobe.
  - Scan: steps autonomously through outputs 0..COUNT-1, holding each for DWELL cycles.
- Used as the row/digit strobe driver for multiplexed displays and as the chip-select generator for small peripheral banks.

---
 rtl/scan_decoder_pkg.sv | 19 +
 rtl/scan_decoder_onehot_dec.sv | 19 +
 rtl/scan_decoder.sv | 101 ++++++++++
 3 files changed

// File: rtl/scan_decoder_pkg.sv
// Shared encodings for the scan decoder: FSM states, mode values, counter sizing.
// Pure declarations; no logic, no latency, no flow control.
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Dwell counter width, never below one bit so DWELL=1 still has a register.
    function automatic int cnt_width(input int dwell);
        return (dwell > 1) ? $clog2(dwell) : 1;
    endfunction

endpackage

// File: rtl/scan_decoder_onehot_dec.sv
// Combinational SEL_W -> 2**SEL_W one-hot decoder with enable (all zero when disabled).
// Zero latency; no backpressure, output follows inputs.
// Polarity is always active-high here; any inversion happens downstream.
module onehot_dec #(
    parameter int SEL_W = 2
) (
    input  logic                  en,
    input  logic [SEL_W-1:0]      sel,
    output logic [2**SEL_W-1:0]   dec
);

    always_comb begin
        dec = '0;
        if (en) begin
            dec[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// One-hot strobe decoder with direct-select and autonomous dwell-timed scan modes.
// One cycle from inputs to registered o/idx/wrap; no backpressure, sel_valid is never stalled.
// en=0 blanks the outputs; out-of-range selects are dropped in scan mode.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int COUNT      = 2**SEL_W,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  sel_valid,
    input  logic [SEL_W-1:0]      sel_in,
    output logic [2**SEL_W-1:0]   o,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap
);

    localparam int               OUT_W    = 2**SEL_W;
    localparam int               CNT_W    = cnt_width(DWELL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W:0]   COUNT_X  = (SEL_W+1)'(COUNT);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(COUNT - 1);
    localparam logic             INV      = (ACTIVE_LOW != 0);

    state_t               state, state_n;
    logic [SEL_W-1:0]     idx_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic                 wrap_n;
    logic                 dec_en;
    logic [OUT_W-1:0]     dec;
    logic                 sel_ok;
    logic                 idx_ok;

    assign sel_ok = ({1'b0, sel_in} < COUNT_X);
    assign idx_ok = ({1'b0, idx} < COUNT_X);

    always_comb begin
        state_n = ST_OFF;
        idx_n   = idx;
        cnt_n   = '0;
        wrap_n  = 1'b0;
        dec_en  = 1'b0;
        if (en) begin
            dec_en = 1'b1;
            if (mode == MODE_DIRECT) begin
                state_n = ST_DIRECT;
                if (sel_valid) begin
                    idx_n = sel_in;
                end
            end else begin
                state_n = ST_SCAN;
                // A legal load beats both scan entry and auto-advance, restarting the dwell.
                if (sel_valid && sel_ok) begin
                    idx_n = sel_in;
                end else if (state != ST_SCAN) begin
                    idx_n = idx_ok ? idx : '0;
                end else if (cnt == CNT_LAST) begin
                    if (idx == IDX_LAST) begin
                        idx_n  = '0;
                        wrap_n = 1'b1;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
        end
    end

    // Decoding the next index keeps o and idx consistent on the same edge.
    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_dec (
        .en  (dec_en),
        .sel (idx_n),
        .dec (dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_OFF;
            idx   <= '0;
            cnt   <= '0;
            wrap  <= 1'b0;
            o     <= {OUT_W{INV}};
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
            wrap  <= wrap_n;
            o     <= dec ^ {OUT_W{INV}};
        end
    end

endmodule
